// File: rtl/pmm_pkg.sv
// rtl/pmm_pkg.sv - shared types and helpers for the pairwise match matrix
// Contents: mode enum, row-count width helper, 32-bit popcount.
package pmm_pkg;

  typedef enum logic [1:0] {
    PMM_LIVE = 2'd0,
    PMM_OR   = 2'd1,
    PMM_AND  = 2'd2,
    PMM_TOL  = 2'd3
  } pmm_mode_e;

  // Width needed to hold a row count of 0..n.
  function automatic int count_width(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int popcount32(input logic [31:0] v);
    int c;
    c = 0;
    for (int k = 0; k < 32; k++) begin
      if (v[k]) c++;
    end
    return c;
  endfunction

endpackage

// File: rtl/pmm_row.sv
// rtl/pmm_row.sv - one row of the match matrix plus its popcount
// Ports:
//   data    in   N*W  registered input vector (lane j = data[j*W +: W])
//   mode    in   2    mode of the vector in data
//   fresh   in   1    accumulator restarts with this sample
//   acc_row in   N    current accumulator row IDX
//   row     out  N    final row IDX (live or accumulated)
//   count   out  CW   popcount of row
module pmm_row
  import pmm_pkg::*;
#(
  parameter int N   = 5,
  parameter int W   = 1,
  parameter int TOL = 0,
  parameter int CW  = count_width(5),
  parameter int IDX = 0
) (
  input  logic [N*W-1:0] data,
  input  pmm_mode_e      mode,
  input  logic           fresh,
  input  logic [N-1:0]   acc_row,
  output logic [N-1:0]   row,
  output logic [CW-1:0]  count
);

  logic [W-1:0] lane_i;
  logic [N-1:0] live_row;

  assign lane_i = data[IDX*W +: W];

  // Tolerance compare counts differing bits; the diagonal has distance 0 so it always matches.
  always_comb begin
    live_row = '0;
    for (int j = 0; j < N; j++) begin
      if (mode == PMM_TOL) begin
        live_row[j] = (popcount32(32'(lane_i ^ data[j*W +: W])) <= TOL);
      end else begin
        live_row[j] = (lane_i == data[j*W +: W]);
      end
    end
  end

  always_comb begin
    case (mode)
      PMM_OR:  row = fresh ? live_row : (acc_row | live_row);
      PMM_AND: row = fresh ? live_row : (acc_row & live_row);
      default: row = live_row;
    endcase
  end

  assign count = CW'(popcount32(32'(row)));

endmodule

// File: rtl/pairwise_match_matrix.sv
// rtl/pairwise_match_matrix.sv - streaming N-lane equality matrix with accumulate and tolerance modes
// Ports:
//   clk, resetn               clock, asynchronous active-low reset
//   in_valid/in_ready/in_data/in_mode   input vector handshake, mode sampled with data
//   clear                     accumulator clear pulse
//   out_valid/out_ready       result handshake
//   out_matrix                bit i*N+j = match(lane i, lane j)
//   out_count                 field i = popcount of row i
//   out_samples               accumulated sample count (0 in live modes)
module pairwise_match_matrix
  import pmm_pkg::*;
#(
  parameter int N   = 5,
  parameter int W   = 1,
  parameter int TOL = 0,
  parameter int CW  = count_width(N)
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*W-1:0]  in_data,
  input  logic [1:0]      in_mode,
  input  logic            clear,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N*N-1:0]  out_matrix,
  output logic [N*CW-1:0] out_count,
  output logic [15:0]     out_samples
);

  logic            s1_valid;
  logic [N*W-1:0]  s1_data;
  pmm_mode_e       s1_mode;
  logic [N*N-1:0]  acc;
  logic            acc_empty;
  pmm_mode_e       last_mode;
  logic [15:0]     acc_samples;

  logic            load;
  logic            accum;
  logic            fresh;
  logic [N*N-1:0]  next_matrix;
  logic [N*CW-1:0] next_count;
  logic [15:0]     next_samples;

  assign load     = s1_valid && (!out_valid || out_ready);
  assign in_ready = !s1_valid || load;
  assign accum    = (s1_mode == PMM_OR) || (s1_mode == PMM_AND);

  // A same-cycle clear or a switch between OR and AND history restarts the accumulator.
  assign fresh        = clear || acc_empty || (s1_mode != last_mode);
  assign next_samples = fresh ? 16'd1 : ((&acc_samples) ? acc_samples : acc_samples + 16'd1);

  for (genvar i = 0; i < N; i++) begin : g_row
    pmm_row #(
      .N  (N),
      .W  (W),
      .TOL(TOL),
      .CW (CW),
      .IDX(i)
    ) u_row (
      .data   (s1_data),
      .mode   (s1_mode),
      .fresh  (fresh),
      .acc_row(acc[i*N +: N]),
      .row    (next_matrix[i*N +: N]),
      .count  (next_count[i*CW +: CW])
    );
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_valid    <= 1'b0;
      s1_data     <= '0;
      s1_mode     <= PMM_LIVE;
      out_valid   <= 1'b0;
      out_matrix  <= '0;
      out_count   <= '0;
      out_samples <= '0;
      acc         <= '0;
      acc_empty   <= 1'b1;
      last_mode   <= PMM_OR;
      acc_samples <= '0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_data <= in_data;
          s1_mode <= pmm_mode_e'(in_mode);
        end
      end

      if (clear) begin
        acc_empty   <= 1'b1;
        acc_samples <= '0;
      end

      if (load) begin
        out_valid  <= 1'b1;
        out_matrix <= next_matrix;
        out_count  <= next_count;
        if (accum) begin
          acc         <= next_matrix;
          acc_empty   <= 1'b0;
          last_mode   <= s1_mode;
          acc_samples <= next_samples;
          out_samples <= next_samples;
        end else begin
          out_samples <= '0;
        end
      end else begin
        if (out_ready) out_valid <= 1'b0;
        if (clear) out_samples <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pairwise_match_matrix.sv
// tb/tb_pairwise_match_matrix.sv - self-checking bench for pairwise_match_matrix
module tb_pairwise_match_matrix;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetn;

  logic        in_valid_a, in_ready_a, clear_a, out_valid_a, out_ready_a;
  logic [4:0]  in_data_a;
  logic [1:0]  in_mode_a;
  logic [24:0] out_matrix_a;
  logic [14:0] out_count_a;
  logic [15:0] out_samples_a;

  logic        in_valid_b, in_ready_b, clear_b, out_valid_b, out_ready_b;
  logic [7:0]  in_data_b;
  logic [1:0]  in_mode_b;
  logic [3:0]  out_matrix_b;
  logic [3:0]  out_count_b;
  logic [15:0] out_samples_b;

  pairwise_match_matrix #(.N(5), .W(1), .TOL(0)) u_a (
    .clk(clk), .resetn(resetn), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .in_data(in_data_a), .in_mode(in_mode_a), .clear(clear_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .out_matrix(out_matrix_a),
    .out_count(out_count_a), .out_samples(out_samples_a)
  );

  pairwise_match_matrix #(.N(2), .W(4), .TOL(1)) u_b (
    .clk(clk), .resetn(resetn), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_data(in_data_b), .in_mode(in_mode_b), .clear(clear_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_matrix(out_matrix_b),
    .out_count(out_count_b), .out_samples(out_samples_b)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    n_vec++;
    n_bad++;
    $display("FAIL %s: bound expired or unexpected event", nm);
  endtask

  // Model: match(i,j) straight from lane values, counts by summing rows.
  function automatic logic [255:0] live_mat(input logic [63:0] d, input int n, input int w,
                                            input int tol, input bit tolm);
    logic [255:0] r;
    logic [63:0]  li, lj, mask;
    r = '0;
    mask = (64'd1 << w) - 64'd1;
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < n; j++) begin
        li = (d >> (i * w)) & mask;
        lj = (d >> (j * w)) & mask;
        r[i*n+j] = tolm ? ($countones(li ^ lj) <= tol) : (li == lj);
      end
    end
    return r;
  endfunction

  function automatic logic [63:0] cnt_pack(input logic [255:0] m, input int n, input int cw);
    logic [63:0] r;
    int c;
    r = '0;
    for (int i = 0; i < n; i++) begin
      c = 0;
      for (int j = 0; j < n; j++) if (m[i*n+j]) c++;
      r = r | (64'(c) << (i * cw));
    end
    return r;
  endfunction

  function automatic logic [24:0] vec5(input logic [4:0] d);
    return ~{{5{d[4]}}, {5{d[3]}}, {5{d[2]}}, {5{d[1]}}, {5{d[0]}}} ^ {5{d}};
  endfunction

  logic [63:0] q_mat_a[$], q_cnt_a[$], q_smp_a[$];
  logic [4:0]  q_dat_a[$];
  logic [63:0] q_mat_b[$], q_cnt_b[$];
  logic [24:0] m_acc;
  bit          m_empty = 1'b1;
  int          m_last = 1;
  int          m_cnt = 0;
  int          acc_count_a = 0;

  task automatic push_a(input logic [4:0] d, input int mode, input bit clr);
    logic [255:0] live;
    logic [24:0]  mat;
    int           smp;
    if (clr) begin
      m_empty = 1'b1;
      m_cnt = 0;
    end
    live = live_mat(64'(d), 5, 1, 0, mode == 3);
    if (mode == 1 || mode == 2) begin
      if (m_empty || mode != m_last) begin
        m_acc = live[24:0];
        m_cnt = 1;
      end else begin
        m_acc = (mode == 1) ? (m_acc | live[24:0]) : (m_acc & live[24:0]);
        if (m_cnt < 65535) m_cnt++;
      end
      m_empty = 1'b0;
      m_last = mode;
      mat = m_acc;
      smp = m_cnt;
    end else begin
      mat = live[24:0];
      smp = 0;
    end
    q_mat_a.push_back(64'(mat));
    q_cnt_a.push_back(cnt_pack(256'(mat), 5, 3));
    q_smp_a.push_back(64'(smp));
    q_dat_a.push_back(d);
  endtask

  // Called at a falling edge; returns at the falling edge after the accepting rising edge.
  task automatic send_a(input logic [4:0] d, input int mode, input bit clr);
    int guard = 0;
    in_valid_a = 1'b1;
    in_data_a = d;
    in_mode_a = 2'(mode);
    #1;
    while (!in_ready_a) begin
      @(negedge clk);
      #1;
      guard++;
      if (guard > 200) begin
        fail("send_a_ready");
        in_valid_a = 1'b0;
        return;
      end
    end
    push_a(d, mode, clr);
    acc_count_a++;
    @(negedge clk);
    in_valid_a = 1'b0;
    if (clr) begin
      clear_a = 1'b1;
      @(negedge clk);
      clear_a = 1'b0;
    end
  endtask

  task automatic send_b(input logic [7:0] d, input int mode);
    int guard = 0;
    logic [255:0] live;
    in_valid_b = 1'b1;
    in_data_b = d;
    in_mode_b = 2'(mode);
    #1;
    while (!in_ready_b) begin
      @(negedge clk);
      #1;
      guard++;
      if (guard > 200) begin
        fail("send_b_ready");
        in_valid_b = 1'b0;
        return;
      end
    end
    live = live_mat(64'(d), 2, 4, 1, mode == 3);
    q_mat_b.push_back(64'(live[3:0]));
    q_cnt_b.push_back(cnt_pack(256'(live[3:0]), 2, 2));
    @(negedge clk);
    in_valid_b = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while ((q_mat_a.size() != 0 || q_mat_b.size() != 0 || out_valid_a || out_valid_b) && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (g >= 200) fail("drain");
  endtask

  bit          hold_a = 1'b0;
  bit          formula_on = 1'b0;
  logic [24:0] hm_a, last_mat_a;
  logic [14:0] hc_a, last_cnt_a;
  logic [15:0] hs_a, last_smp_a;
  logic [4:0]  dat_a;
  logic [3:0]  last_mat_b, last_cnt_b;

  always begin
    @(negedge clk);
    #1;
    if (!resetn) begin
      hold_a = 1'b0;
    end else begin
      if (hold_a) begin
        chk("hold_matrix", 64'(out_matrix_a), 64'(hm_a));
        chk("hold_count", 64'(out_count_a), 64'(hc_a));
        chk("hold_samples", 64'(out_samples_a), 64'(hs_a));
      end
      if (out_valid_a && out_ready_a) begin
        if (q_mat_a.size() == 0) begin
          fail("extra_output_a");
        end else begin
          chk("matrix_a", 64'(out_matrix_a), q_mat_a.pop_front());
          chk("count_a", 64'(out_count_a), q_cnt_a.pop_front());
          chk("samples_a", 64'(out_samples_a), q_smp_a.pop_front());
          dat_a = q_dat_a.pop_front();
          if (formula_on) chk("vec5_formula", 64'(out_matrix_a), 64'(vec5(dat_a)));
          last_mat_a = out_matrix_a;
          last_cnt_a = out_count_a;
          last_smp_a = out_samples_a;
        end
      end
      hold_a = out_valid_a && !out_ready_a;
      hm_a = out_matrix_a;
      hc_a = out_count_a;
      hs_a = out_samples_a;
      if (out_valid_b && out_ready_b) begin
        if (q_mat_b.size() == 0) begin
          fail("extra_output_b");
        end else begin
          chk("matrix_b", 64'(out_matrix_b), q_mat_b.pop_front());
          chk("count_b", 64'(out_count_b), q_cnt_b.pop_front());
          chk("samples_b", 64'(out_samples_b), 64'd0);
          last_mat_b = out_matrix_b;
          last_cnt_b = out_count_b;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    resetn = 1'b0;
    in_valid_a = 1'b0; in_data_a = '0; in_mode_a = '0; clear_a = 1'b0; out_ready_a = 1'b1;
    in_valid_b = 1'b0; in_data_b = '0; in_mode_b = '0; clear_b = 1'b0; out_ready_b = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_out_valid", 64'(out_valid_a), 64'd0);
    chk("reset_matrix", 64'(out_matrix_a), 64'd0);
    chk("reset_count", 64'(out_count_a), 64'd0);
    chk("reset_samples", 64'(out_samples_a), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    chk("reset_in_ready", 64'(in_ready_a), 64'd1);
    @(negedge clk);

    // All 32 live-exact patterns back to back.
    formula_on = 1'b1;
    for (int p = 0; p < 32; p++) send_a(5'(p), 0, 1'b0);
    drain();
    formula_on = 1'b0;

    send_a(5'b00000, 0, 1'b0);
    drain();
    chk("lit_zero_matrix", 64'(last_mat_a), 64'h1FFFFFF);
    chk("lit_zero_count", 64'(last_cnt_a), 64'({5{3'd5}}));

    // Exactly two cycles from acceptance to out_valid.
    send_a(5'b10000, 0, 1'b0);
    #1;
    chk("latency_edge1", 64'(out_valid_a), 64'd0);
    @(negedge clk);
    #1;
    chk("latency_edge2", 64'(out_valid_a), 64'd1);
    chk("lit_10000_matrix", 64'(out_matrix_a), 64'({5'b10000, 5'b01111, 5'b01111, 5'b01111, 5'b01111}));
    chk("lit_10000_count", 64'(out_count_a), 64'({3'd1, 3'd4, 3'd4, 3'd4, 3'd4}));
    @(negedge clk);
    drain();

    // Backpressure: three vectors offered while the output is stalled.
    base = acc_count_a;
    out_ready_a = 1'b0;
    fork
      begin
        send_a(5'h01, 0, 1'b0);
        send_a(5'h02, 0, 1'b0);
        send_a(5'h04, 0, 1'b0);
      end
      begin
        repeat (4) @(negedge clk);
        #1;
        chk("bp_accepted", 64'(acc_count_a - base), 64'd2);
        chk("bp_in_ready", 64'(in_ready_a), 64'd0);
        @(negedge clk);
        out_ready_a = 1'b1;
      end
    join
    drain();

    // Accumulate-AND.
    send_a(5'b00000, 2, 1'b0);
    send_a(5'b00001, 2, 1'b0);
    drain();
    chk("and_matrix", 64'(last_mat_a), 64'({5'b11110, 5'b11110, 5'b11110, 5'b11110, 5'b00001}));
    chk("and_count", 64'(last_cnt_a), 64'({3'd4, 3'd4, 3'd4, 3'd4, 3'd1}));
    chk("and_samples", 64'(last_smp_a), 64'd2);

    clear_a = 1'b1;
    m_empty = 1'b1;
    m_cnt = 0;
    @(negedge clk);
    clear_a = 1'b0;
    #1;
    chk("idle_clear_samples", 64'(out_samples_a), 64'd0);
    chk("idle_clear_matrix", 64'(out_matrix_a), 64'({5'b11110, 5'b11110, 5'b11110, 5'b11110, 5'b00001}));
    @(negedge clk);

    send_a(5'b00011, 2, 1'b0);
    send_a(5'b00000, 2, 1'b1);
    drain();
    chk("clear_load_samples", 64'(last_smp_a), 64'd1);
    chk("clear_load_matrix", 64'(last_mat_a), 64'h1FFFFFF);

    send_a(5'b00101, 0, 1'b0);
    send_a(5'b00111, 2, 1'b0);
    send_a(5'b01000, 1, 1'b0);
    drain();
    chk("mode_switch_samples", 64'(last_smp_a), 64'd1);
    send_a(5'b10000, 1, 1'b0);
    send_a(5'b01010, 3, 1'b0);
    send_a(5'b00110, 1, 1'b0);
    drain();

    // Reset with both stages full.
    out_ready_a = 1'b0;
    send_a(5'h03, 1, 1'b0);
    send_a(5'h05, 1, 1'b0);
    #1;
    chk("pre_reset_full", 64'(out_valid_a), 64'd1);
    #1;
    resetn = 1'b0;
    #1;
    chk("async_reset_valid", 64'(out_valid_a), 64'd0);
    chk("async_reset_matrix", 64'(out_matrix_a), 64'd0);
    chk("async_reset_count", 64'(out_count_a), 64'd0);
    chk("async_reset_samples", 64'(out_samples_a), 64'd0);
    q_mat_a.delete(); q_cnt_a.delete(); q_smp_a.delete(); q_dat_a.delete();
    m_empty = 1'b1;
    m_cnt = 0;
    @(negedge clk);
    out_ready_a = 1'b1;
    #3;
    resetn = 1'b1;
    @(negedge clk);
    #1;
    chk("post_reset_ready", 64'(in_ready_a), 64'd1);
    @(negedge clk);
    send_a(5'h06, 1, 1'b0);
    drain();
    chk("post_reset_samples", 64'(last_smp_a), 64'd1);

    // Two lanes of four bits, tolerance 1.
    send_b(8'hBA, 3);
    drain();
    chk("tol_dist1_matrix", 64'(last_mat_b), 64'h0F);
    chk("tol_dist1_count", 64'(last_cnt_b), 64'({2'd2, 2'd2}));
    send_b(8'h3A, 3);
    drain();
    chk("tol_dist2_matrix", 64'(last_mat_b), 64'h09);
    chk("tol_dist2_count", 64'(last_cnt_b), 64'({2'd1, 2'd1}));
    send_b(8'hAA, 0);
    send_b(8'hBA, 0);
    send_b(8'h7A, 3);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
